updown_counter: RTL and testbench

Parametrised synchronous up/down modulo counter. It generalises the fixed 3-bit binary up/down counter with a configurable width and modulus, plus enable, parallel load, wrap or saturate mode, and a registered terminal-count flag. It is a drop-in sequencing/count source for display, timing and stimulus logic in the counter family. An optional Gray-coded output can be compiled in.

---
 rtl/updown_counter.sv | 102 ++++++++++
 tb/tb_updown_counter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Parametrised synchronous up/down modulo counter with enable, clamped parallel
// load, wrap/saturate mode and registered terminal count. Define UPDOWN_GRAY_EN to add a registered Gray output.
module updown_counter #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_GRAY_EN
    output logic [WIDTH-1:0] gray,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam int AW = WIDTH + 1;
    localparam logic [AW-1:0] MOD_W = AW'(MODULUS);
    localparam logic [AW-1:0] TOP_W = AW'(MODULUS - 1);

    logic [WIDTH-1:0] count_p0;
    logic             tc_p0;
    logic [WIDTH-1:0] next_count;
    logic             next_tc;

    // Out-of-range load values are clamped to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] lv);
        logic [AW-1:0] lv_e;
        lv_e = {1'b0, lv};
        if (lv_e < MOD_W)
            return lv;
        return TOP_W[WIDTH-1:0];
    endfunction

    function automatic logic at_boundary(input logic [WIDTH-1:0] c, input logic up);
        logic [AW-1:0] c_e;
        c_e = {1'b0, c};
        if (c_e >= MOD_W)
            return 1'b0;
        if (up)
            return (c_e == TOP_W);
        return (c_e == '0);
    endfunction

    // Saturation or wrap at the range ends; an illegal count recovers to zero.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c, input logic up);
        logic [AW-1:0] c_e;
        logic [AW-1:0] n_e;
        c_e = {1'b0, c};
        if (c_e >= MOD_W)
            n_e = '0;
        else if (up)
            n_e = (c_e == TOP_W) ? (SATURATE ? c_e : '0) : c_e + AW'(1);
        else
            n_e = (c_e == '0) ? (SATURATE ? c_e : TOP_W) : c_e - AW'(1);
        return n_e[WIDTH-1:0];
    endfunction

    always_comb begin
        next_count = count_p0;
        next_tc    = 1'b0;
        if (load) begin
            next_count = clamp_load(load_val);
        end else if (en) begin
            next_count = step_count(count_p0, dir);
            next_tc    = at_boundary(count_p0, dir);
        end
    end

    // Stage p0: count and terminal-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p0 <= '0;
            tc_p0    <= 1'b0;
        end else begin
            count_p0 <= next_count;
            tc_p0    <= next_tc;
        end
    end

    assign count = count_p0;
    assign tc    = tc_p0;

`ifdef UPDOWN_GRAY_EN
    logic [WIDTH-1:0] gray_p0;

    // Gray is taken from next_count so it lines up with count in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            gray_p0 <= '0;
        else
            gray_p0 <= next_count ^ (next_count >> 1);
    end

    assign gray = gray_p0;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (mod 8 wrap, mod 10 wrap, mod 8 saturate)
// share control inputs and are compared against a plain-arithmetic reference model.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [2:0] lv3 = '0;
    logic [3:0] lv4 = '0;
    logic [2:0] c0, c2;
    logic [3:0] c1;
    logic       t0, t1, t2;
`ifdef UPDOWN_GRAY_EN
    logic [2:0] g0, g2;
    logic [3:0] g1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int mods[3] = '{8, 10, 8};
    int wids[3] = '{3, 4, 3};
    bit sats[3] = '{1'b0, 1'b0, 1'b1};
    int exp_cnt[3];
    int exp_tc[3];
    int obs_cnt[3];
    int obs_tc[3];
    int obs_gray[3];

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv3),
`ifdef UPDOWN_GRAY_EN
        .gray(g0),
`endif
        .count(c0), .tc(t0));

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv4),
`ifdef UPDOWN_GRAY_EN
        .gray(g1),
`endif
        .count(c1), .tc(t1));

    updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(lv3),
`ifdef UPDOWN_GRAY_EN
        .gray(g2),
`endif
        .count(c2), .tc(t2));

    always_comb begin
        obs_cnt[0] = int'(c0);
        obs_cnt[1] = int'(c1);
        obs_cnt[2] = int'(c2);
        obs_tc[0]  = int'(t0);
        obs_tc[1]  = int'(t1);
        obs_tc[2]  = int'(t2);
`ifdef UPDOWN_GRAY_EN
        obs_gray[0] = int'(g0);
        obs_gray[1] = int'(g1);
        obs_gray[2] = int'(g2);
`else
        obs_gray[0] = 0;
        obs_gray[1] = 0;
        obs_gray[2] = 0;
`endif
    end

    // Reference: one edge of a modulo counter described by its rules.
    function automatic void model(input int k, input bit r, input bit l, input int lv,
                                  input bit e, input bit d);
        int m;
        int v;
        m = mods[k];
        v = lv % (1 << wids[k]);
        if (r) begin
            exp_cnt[k] = 0;
            exp_tc[k]  = 0;
        end else if (l) begin
            exp_cnt[k] = (v < m) ? v : m - 1;
            exp_tc[k]  = 0;
        end else if (e) begin
            if (d) begin
                exp_tc[k]  = (exp_cnt[k] == m - 1) ? 1 : 0;
                exp_cnt[k] = (exp_cnt[k] == m - 1) ? (sats[k] ? m - 1 : 0) : exp_cnt[k] + 1;
            end else begin
                exp_tc[k]  = (exp_cnt[k] == 0) ? 1 : 0;
                exp_cnt[k] = (exp_cnt[k] == 0) ? (sats[k] ? 0 : m - 1) : exp_cnt[k] - 1;
            end
        end else begin
            exp_tc[k] = 0;
        end
    endfunction

    task automatic tick(input bit r, input bit l, input int lv, input bit e, input bit d);
        rst  = r;
        load = l;
        lv3  = 3'(lv);
        lv4  = 4'(lv);
        en   = e;
        dir  = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++)
            model(k, r, l, lv, e, d);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_cnt[k] !== 0 || obs_tc[k] !== 0 || obs_gray[k] !== 0) begin
                n_fail++;
                $display("FAIL reset dut%0d: count=%0d tc=%0d gray=%0d, expected 0/0/0",
                         k, obs_cnt[k], obs_tc[k], obs_gray[k]);
            end
        end
    endtask

    task automatic test_up_wrap();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
            n_tests++;
            if (obs_cnt[0] !== i % 8 || obs_tc[0] !== int'(i == 8)) begin
                n_fail++;
                $display("FAIL up_wrap step%0d: count=%0d tc=%0d, expected %0d/%0d",
                         i, obs_cnt[0], obs_tc[0], i % 8, int'(i == 8));
            end
        end
        n_tests++;
        if (obs_cnt[2] !== 7 || obs_tc[2] !== 1) begin
            n_fail++;
            $display("FAIL up_sat_hold: count=%0d tc=%0d, expected 7/1", obs_cnt[2], obs_tc[2]);
        end
    endtask

    task automatic test_down_wrap();
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (obs_cnt[0] !== 7 || obs_tc[0] !== 1) begin
            n_fail++;
            $display("FAIL down_wrap: count=%0d tc=%0d, expected 7/1", obs_cnt[0], obs_tc[0]);
        end
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (obs_cnt[0] !== 6 || obs_tc[0] !== 0) begin
            n_fail++;
            $display("FAIL down_after_wrap: count=%0d tc=%0d, expected 6/0", obs_cnt[0], obs_tc[0]);
        end
        tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
        n_tests++;
        if (obs_cnt[0] !== 6 || obs_tc[0] !== 0) begin
            n_fail++;
            $display("FAIL hold: count=%0d tc=%0d, expected 6/0", obs_cnt[0], obs_tc[0]);
        end
    endtask

    task automatic test_mod10();
        int ec[4] = '{8, 9, 0, 9};
        int et[4] = '{0, 0, 1, 0};
        tick(1'b0, 1'b1, 8, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1 || i == 2)
                tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
            else if (i == 3)
                tick(1'b0, 1'b1, 12, 1'b1, 1'b1);
            n_tests++;
            if (obs_cnt[1] !== ec[i] || obs_tc[1] !== et[i]) begin
                n_fail++;
                $display("FAIL mod10 step%0d: count=%0d tc=%0d, expected %0d/%0d",
                         i, obs_cnt[1], obs_tc[1], ec[i], et[i]);
            end
        end
    endtask

    task automatic test_saturate();
        tick(1'b0, 1'b1, 7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
            n_tests++;
            if (obs_cnt[2] !== 7 || obs_tc[2] !== 1) begin
                n_fail++;
                $display("FAIL sat_top cycle%0d: count=%0d tc=%0d, expected 7/1",
                         i, obs_cnt[2], obs_tc[2]);
            end
        end
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (obs_cnt[2] !== 6 || obs_tc[2] !== 0) begin
            n_fail++;
            $display("FAIL sat_turn: count=%0d tc=%0d, expected 6/0", obs_cnt[2], obs_tc[2]);
        end
        tick(1'b0, 1'b1, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
        n_tests++;
        if (obs_cnt[2] !== 0 || obs_tc[2] !== 1) begin
            n_fail++;
            $display("FAIL sat_bottom: count=%0d tc=%0d, expected 0/1", obs_cnt[2], obs_tc[2]);
        end
    endtask

    task automatic test_priority();
        tick(1'b0, 1'b1, 3, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_cnt[k] !== 3 || obs_tc[k] !== 0) begin
                n_fail++;
                $display("FAIL load_over_en dut%0d: count=%0d tc=%0d, expected 3/0",
                         k, obs_cnt[k], obs_tc[k]);
            end
        end
        tick(1'b1, 1'b1, 5, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (obs_cnt[k] !== 0 || obs_tc[k] !== 0) begin
                n_fail++;
                $display("FAIL rst_over_load dut%0d: count=%0d tc=%0d, expected 0/0",
                         k, obs_cnt[k], obs_tc[k]);
            end
        end
    endtask

`ifdef UPDOWN_GRAY_EN
    task automatic test_gray();
        int gtab[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        tick(1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0)
                tick(1'b0, 1'b0, 0, 1'b1, 1'b1);
            n_tests++;
            if (obs_gray[0] !== gtab[i] || obs_cnt[0] !== i % 8) begin
                n_fail++;
                $display("FAIL gray step%0d: gray=%0d count=%0d, expected %0d/%0d",
                         i, obs_gray[0], obs_cnt[0], gtab[i], i % 8);
            end
        end
    endtask
`endif

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom));
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (obs_cnt[k] !== exp_cnt[k] || obs_tc[k] !== exp_tc[k]
`ifdef UPDOWN_GRAY_EN
                    || obs_gray[k] !== (exp_cnt[k] ^ (exp_cnt[k] >> 1))
`endif
                   ) begin
                    n_fail++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random cyc%0d dut%0d: count=%0d tc=%0d, expected %0d/%0d",
                                 i, k, obs_cnt[k], obs_tc[k], exp_cnt[k], exp_tc[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_mod10();
        test_saturate();
        test_priority();
`ifdef UPDOWN_GRAY_EN
        test_gray();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
